// File: rtl/muldiv_pkg.sv
// Shared widths, opcodes and FSM states for the iterative multiply/divide unit.
package muldiv_pkg;
    localparam int WORD_SIZE     = 16;
    localparam int REG_ADDR_BITS = 2;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_DIVQ = 2'b01,
        OP_DIVR = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_WB   = 2'b10
    } state_e;

    function automatic logic is_div_op(input op_e op);
        return (op == OP_DIVQ) || (op == OP_DIVR);
    endfunction
endpackage

// File: rtl/muldiv_unit_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module muldiv_step #(
    parameter int WORD_SIZE = muldiv_pkg::WORD_SIZE
) (
    input  logic                 i_is_div,
    input  logic [WORD_SIZE-1:0] i_a,    // multiplicand, or dividend shifting into quotient
    input  logic [WORD_SIZE-1:0] i_b,    // multiplier, or divisor
    input  logic [WORD_SIZE-1:0] i_acc,  // product accumulator, or partial remainder
    output logic [WORD_SIZE-1:0] o_a,
    output logic [WORD_SIZE-1:0] o_b,
    output logic [WORD_SIZE-1:0] o_acc
);
    // The bit shifted out of the remainder is kept so divisors above 2^(W-1) still compare correctly.
    logic [WORD_SIZE:0] w_rem_sh;

    always_comb begin
        o_a      = i_a;
        o_b      = i_b;
        o_acc    = i_acc;
        w_rem_sh = {i_acc, i_a[WORD_SIZE-1]};
        if (i_is_div) begin
            if (w_rem_sh >= {1'b0, i_b}) begin
                o_acc = w_rem_sh[WORD_SIZE-1:0] - i_b;
                o_a   = {i_a[WORD_SIZE-2:0], 1'b1};
            end else begin
                o_acc = w_rem_sh[WORD_SIZE-1:0];
                o_a   = {i_a[WORD_SIZE-2:0], 1'b0};
            end
        end else begin
            if (i_b[0]) o_acc = i_acc + i_a;
            o_a = i_a << 1;
            o_b = i_b >> 1;
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned MUL/DIVQ/DIVR unit: IDLE -> RUN (WORD_SIZE steps) -> WB, one RF write per op.
module muldiv_unit #(
    parameter int WORD_SIZE     = muldiv_pkg::WORD_SIZE,
    parameter int REG_ADDR_BITS = muldiv_pkg::REG_ADDR_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [1:0]               op,
    input  logic [WORD_SIZE-1:0]     src_a,
    input  logic [WORD_SIZE-1:0]     src_b,
    input  logic [REG_ADDR_BITS-1:0] dest,
    output logic                     busy,
    output logic                     done,
    output logic                     wb_write,
    output logic [REG_ADDR_BITS-1:0] wb_addr,
    output logic [WORD_SIZE-1:0]     wb_data
);
    import muldiv_pkg::*;

    localparam int CNT_W = $clog2(WORD_SIZE) + 1;

    state_e                   r_state;
    op_e                      r_op;
    logic [CNT_W-1:0]         r_cnt;
    logic [WORD_SIZE-1:0]     r_a, r_b, r_acc;
    logic [REG_ADDR_BITS-1:0] r_dest;
    logic                     r_busy, r_done, r_wb_write;
    logic [REG_ADDR_BITS-1:0] r_wb_addr;
    logic [WORD_SIZE-1:0]     r_wb_data;

    logic [WORD_SIZE-1:0]     w_a, w_b, w_acc;
    logic                     w_new_div;

    assign w_new_div = is_div_op(op_e'(op));

    muldiv_step #(.WORD_SIZE(WORD_SIZE)) u_step (
        .i_is_div (is_div_op(r_op)),
        .i_a      (r_a),
        .i_b      (r_b),
        .i_acc    (r_acc),
        .o_a      (w_a),
        .o_b      (w_b),
        .o_acc    (w_acc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_MUL;
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_dest     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_wb_write <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
        end else begin
            r_done     <= 1'b0;
            r_wb_write <= 1'b0;
            r_wb_data  <= '0;
            case (r_state)
                ST_IDLE: begin
                    r_busy <= 1'b0;
                    if (start) begin
                        r_op   <= op_e'(op);
                        r_dest <= dest;
                        r_a    <= src_a;
                        r_b    <= src_b;
                        r_acc  <= '0;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                        if (w_new_div && (src_b == '0)) begin
                            // Divide by zero skips the loop: quotient saturates, remainder is the dividend.
                            r_state    <= ST_WB;
                            r_done     <= 1'b1;
                            r_wb_write <= 1'b1;
                            r_wb_addr  <= dest;
                            r_wb_data  <= (op_e'(op) == OP_DIVQ) ? '1 : src_a;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    r_a   <= w_a;
                    r_b   <= w_b;
                    r_acc <= w_acc;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WORD_SIZE - 1)) begin
                        r_state    <= ST_WB;
                        r_done     <= 1'b1;
                        r_wb_write <= 1'b1;
                        r_wb_addr  <= r_dest;
                        r_wb_data  <= (r_op == OP_DIVQ) ? w_a : w_acc;
                    end
                end
                ST_WB: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign wb_write = r_wb_write;
    assign wb_addr  = r_wb_addr;
    assign wb_data  = r_wb_data;
endmodule
